mantissa_mult_seq: RTL and testbench
====================================

// Module: mantissa_mult_seq
// PURPOSE
//   Sequential shift-and-add multiplier for the 24-bit significands (hidden bit included)
//   of two IEEE-754 single-precision operands. It produces the raw 48-bit product that
//   feeds the normalizer stage. That stage selects the 23-bit mantissa and inc_exp from
//   product[47:46].
//   One multiply is in flight at a time, with a start/busy/done handshake.
// PARAMETERS
//   MW   24       significand width including hidden bit
//   PW   2*MW     product width (derived; do not override)
// PORTS
//   clk      in   1    clock, rising-edge
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    request a multiply; sampled only when busy==0
//   mant_a   in   MW   significand A, sampled on the accepting edge
//   mant_b   in   MW   significand B, sampled on the accepting edge
//   busy     out  1    high while in CALC
//   done     out  1    one-cycle pulse: product is valid
//   product  out  PW   A*B, unsigned; held until the next accepted start completes
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, product=0; internal A/P/count regs cleared.
//   - Deassertion is synchronised to clk internally.
//   States: IDLE, CALC, DONE.
//   - IDLE: start=1 -> latch A=mant_a and P={MW'b0, mant_b}; count=0.
//     - If mant_a==0 or mant_b==0: go to DONE with P=0 (zero early-out).
//     - Otherwise go to CALC.
//   - CALC: each edge:
//     - sum[MW:0] = P[PW-1:MW] + (P[0] ? A : 0).
//     - P <= {sum, P[MW-1:1]}; count++.
//     - After the MW-th iteration (count==MW-1), go to DONE.
//   - DONE: present for exactly one cycle.
//     - done=1; product is loaded from P on the edge entering DONE.
//     - Next state: CALC/DONE if start=1 (accepted as in IDLE, back-to-back); otherwise IDLE.
//   Latency, start accepted at edge T0:
//   - Nonzero operands: MW iterations at edges T1..T24; state=DONE after T24; done=1 in
//     cycle T24..T25. That is 25 cycles from start to done.
//   - Zero operand: done=1 in cycle T0..T1.
//   Handshake:
//   - busy=1 exactly while in CALC.
//   - start while busy=1 is ignored (no queueing), and operands are not re-sampled.
//   - done never asserts for more than one consecutive cycle per accepted start.
//   Arithmetic:
//   - Unsigned and exact; no rounding or truncation.
//   - The sum carry (bit MW) is kept in P, so the full 2*MW-bit result is always exact.
//   - product[PW-1] set means the significand product is >= 2.0, which the normalizer
//     handles.
//   Boundaries:
//   - product changes only on the edge entering DONE; it is stable otherwise.
//   - Reset mid-CALC aborts immediately: state=IDLE, product=0, no done pulse.
//   - start held high continuously gives one multiply every 25 cycles, with operands
//     re-sampled each time.
//   - Inputs are don't-care except on the accepting edge.
// TESTING
//   1. a=b=24'h800000 (1.0*1.0), start 1 cycle -> done 25 cycles later,
//      product=48'h4000_0000_0000; busy high 24 cycles.
//   2. a=b=24'hC00000 (1.5*1.5) -> product=48'h9000_0000_0000 (bit47=1, normalizer
//      sets inc_exp).
//   3. a=b=24'hFFFFFF -> product=48'hFFFF_FE00_0001; no carry lost.
//   4. a=24'h000000, b=24'hABCDEF -> done on the cycle after start, product=0, busy
//      never asserted.
//   5. Start (a=b=24'h800000); at cycle 10 pulse start with a=b=24'hFFFFFF -> ignored;
//      result 48'h4000_0000_0000 with a single done.
//   6. rst_n=0 at cycle 12 of CALC -> busy/done/product=0 immediately; after release a
//      new start (24'hC00000^2) gives 48'h9000_0000_0000.

Source files
------------

// File: rtl/mantissa_mult_seq.sv
// Sequential shift-and-add multiplier for 24-bit IEEE-754 significands.
// Produces the exact 48-bit unsigned product with a start/busy/done handshake.
module mantissa_mult_seq #(
  parameter int MW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [MW-1:0]   i_mant_a,
  input  logic [MW-1:0]   i_mant_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*MW-1:0] o_product
);

  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [MW-1:0]   r_a;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_product;
  logic [MW:0]     w_sum;
  logic [PW-1:0]   w_p_next;
  logic            w_zero_op;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // The carry out of the upper half lands in P[PW-1] as the register shifts right.
  assign w_sum     = {1'b0, r_p[PW-1:MW]} + (r_p[0] ? {1'b0, r_a} : {(MW+1){1'b0}});
  assign w_p_next  = {w_sum, r_p[MW-1:1]};
  assign w_zero_op = (i_mant_a == '0) || (i_mant_b == '0);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_p       <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_a     <= i_mant_a;
            r_count <= '0;
            if (w_zero_op) begin
              r_p       <= '0;
              r_product <= '0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_p     <= {{MW{1'b0}}, i_mant_b};
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_p     <= w_p_next;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(MW - 1)) begin
            r_product <= w_p_next;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_mantissa_mult_seq.sv
// Directed bench for mantissa_mult_seq: vector table plus hand-written
// sequences for the ignored start, reset mid-multiply and back-to-back starts.
module tb_mantissa_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [23:0] i_mant_a;
  logic [23:0] i_mant_b;
  logic        o_busy;
  logic        o_done;
  logic [47:0] o_product;

  int n_checks = 0;
  int n_pass   = 0;

  mantissa_mult_seq #(.MW(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_mant_a  (i_mant_a),
    .i_mant_b  (i_mant_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
    int          lat;
    int          busy;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int busy_cnt;
    bit got;
    @(negedge clk);
    i_start  = 1'b1;
    i_mant_a = v.a;
    i_mant_b = v.b;
    cyc = 0;
    busy_cnt = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      i_start  = 1'b0;
      i_mant_a = 24'($urandom);
      i_mant_b = 24'($urandom);
      cyc++;
      if (o_busy) busy_cnt++;
      if (o_done) got = 1;
    end
    $display("vec %s: a=%h b=%h product=%h latency=%0d busy=%0d",
             v.name, v.a, v.b, o_product, cyc, busy_cnt);
    check({v.name, ".latency"}, 64'(cyc), 64'(v.lat));
    check({v.name, ".busy"}, 64'(busy_cnt), 64'(v.busy));
    check({v.name, ".product"}, 64'(o_product), 64'(v.p));
    @(negedge clk);
    check({v.name, ".done_once"}, 64'(o_done), 64'd0);
    check({v.name, ".held"}, 64'(o_product), 64'(v.p));
  endtask

  initial begin
    int cyc;
    int n_done;
    int done_cyc[2];
    logic [47:0] done_prod[2];

    vecs[0] = '{24'h800000, 24'h800000, 48'h4000_0000_0000, 25, 24, "one_x_one"};
    vecs[1] = '{24'hC00000, 24'hC00000, 48'h9000_0000_0000, 25, 24, "1p5_sq"};
    vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001, 25, 24, "max_sq"};
    vecs[3] = '{24'h000000, 24'hABCDEF, 48'h0,              1,  0,  "zero_a"};
    vecs[4] = '{24'h000001, 24'h000001, 48'h1,              25, 24, "one_lsb"};
    vecs[5] = '{24'hABCDEF, 24'h000000, 48'h0,              1,  0,  "zero_b"};
    vecs[6] = '{24'h000002, 24'h000003, 48'h6,              25, 24, "two_x_three"};
    vecs[7] = '{24'hFFFFFF, 24'h000001, 48'hFF_FFFF,        25, 24, "max_x_one"};
    vecs[8] = '{24'h123456, 24'h000010, 48'h123_4560,       25, 24, "shift4"};
    vecs[9] = '{24'h800001, 24'h800001, 48'h4000_0100_0001, 25, 24, "near_one_sq"};

    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_mant_a = '0;
    i_mant_b = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(o_busy), 64'd0);
    check("reset.done", 64'(o_done), 64'd0);
    check("reset.product", 64'(o_product), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Start ignored while busy: operands must not be re-sampled.
    @(negedge clk);
    i_start  = 1'b1;
    i_mant_a = 24'h800000;
    i_mant_b = 24'h800000;
    n_done = 0;
    done_cyc[0] = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      i_start = (cyc == 10);
      if (cyc == 10) begin
        i_mant_a = 24'hFFFFFF;
        i_mant_b = 24'hFFFFFF;
      end
      if (cyc == 24) check("ignore.product_stable", 64'(o_product), 64'h4000_0100_0001);
      if (o_done) begin
        n_done++;
        done_cyc[0] = cyc;
        done_prod[0] = o_product;
      end
    end
    $display("seq ignore_start: dones=%0d at cycle %0d product=%h", n_done, done_cyc[0], done_prod[0]);
    check("ignore.done_count", 64'(n_done), 64'd1);
    check("ignore.done_cycle", 64'(done_cyc[0]), 64'd25);
    check("ignore.product", 64'(done_prod[0]), 64'h4000_0000_0000);

    // Reset in the middle of CALC aborts at once, no done afterwards.
    @(negedge clk);
    i_start  = 1'b1;
    i_mant_a = 24'hC00000;
    i_mant_b = 24'hC00000;
    repeat (12) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    check("abort.busy_before", 64'(o_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 64'(o_busy), 64'd0);
    check("abort.done", 64'(o_done), 64'd0);
    check("abort.product", 64'(o_product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_done || o_busy) n_done++;
    end
    $display("seq reset_abort: activity after reset=%0d", n_done);
    check("abort.no_done", 64'(n_done), 64'd0);
    run_vec(vecs[1]);

    // Start held high: one multiply per 25 cycles, operands re-sampled.
    @(negedge clk);
    i_start  = 1'b1;
    i_mant_a = 24'h800000;
    i_mant_b = 24'h800000;
    n_done = 0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        i_mant_a = 24'hC00000;
        i_mant_b = 24'hC00000;
      end
      if (cyc == 26) i_start = 1'b0;
      if (o_done) begin
        if (n_done < 2) begin
          done_cyc[n_done]  = cyc;
          done_prod[n_done] = o_product;
        end
        n_done++;
      end
    end
    $display("seq back_to_back: dones=%0d at %0d,%0d products=%h,%h",
             n_done, done_cyc[0], done_cyc[1], done_prod[0], done_prod[1]);
    check("b2b.done_count", 64'(n_done), 64'd2);
    check("b2b.first_cycle", 64'(done_cyc[0]), 64'd25);
    check("b2b.first_product", 64'(done_prod[0]), 64'h4000_0000_0000);
    check("b2b.second_cycle", 64'(done_cyc[1]), 64'd50);
    check("b2b.second_product", 64'(done_prod[1]), 64'h9000_0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
